note_sequencer: RTL and testbench

//  Upstream stage of the square-wave oscillator: steps through a fixed 16-step melody

---
 rtl/note_sequencer_pkg.sv | 41 ++++
 rtl/note_sequencer_if.sv | 30 +++
 rtl/note_sequencer_step_timer.sv | 52 +++++
 rtl/note_sequencer.sv | 147 ++++++++++++++
 tb/tb_note_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared audio-path types: note encoding (also consumed by the square-wave
// oscillator), pattern step record, sequencer state and the built-in melody.
package iv_audio_pkg;

  // Oscillator note select, 2 bits wide.
  typedef enum logic [1:0] {
    NOTE_FS5 = 2'd0,
    NOTE_A5  = 2'd1,
    NOTE_CS6 = 2'd2,
    NOTE_E6  = 2'd3
  } note_t;

  // One pattern step. When rest is set, the note field is ignored.
  typedef struct packed {
    logic  rest;
    note_t note;
  } step_t;

  // Sequencer control state, exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int PATTERN_MAX = 16;

  // Melody: F#5 A5 C#6 E6 C#6 A5 F#5 R A5 C#6 E6 C#6 A5 F#5 A5 R
  localparam step_t DEFAULT_PATTERN [0:PATTERN_MAX-1] = '{
    '{1'b0, NOTE_FS5}, '{1'b0, NOTE_A5 }, '{1'b0, NOTE_CS6}, '{1'b0, NOTE_E6 },
    '{1'b0, NOTE_CS6}, '{1'b0, NOTE_A5 }, '{1'b0, NOTE_FS5}, '{1'b1, NOTE_FS5},
    '{1'b0, NOTE_A5 }, '{1'b0, NOTE_CS6}, '{1'b0, NOTE_E6 }, '{1'b0, NOTE_CS6},
    '{1'b0, NOTE_A5 }, '{1'b0, NOTE_FS5}, '{1'b0, NOTE_A5 }, '{1'b1, NOTE_FS5}
  };

  // Pattern lookup by step index.
  function automatic step_t pattern_step(input logic [3:0] idx);
    return DEFAULT_PATTERN[idx];
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the playback controller (master) and the
// note sequencer (slave).
//
// Handshake: there is no valid/ready pair here. START and STOP are single-cycle
// command pulses that are always accepted on the clock edge they are high;
// STOP takes priority when both are high. DONE is a single-cycle status pulse.
// All sequencer outputs are registered.
interface note_sequencer_if;
  import iv_audio_pkg::*;

  logic       START;
  logic       STOP;
  note_t      NOTE_SEL;
  logic       GATE;
  logic [3:0] STEP_IDX;
  logic       BUSY;
  logic       DONE;
  seq_state_t dbg_state;

  modport master (
    output START, STOP,
    input  NOTE_SEL, GATE, STEP_IDX, BUSY, DONE, dbg_state
  );

  modport slave (
    input  START, STOP,
    output NOTE_SEL, GATE, STEP_IDX, BUSY, DONE, dbg_state
  );

endinterface

// File: rtl/note_sequencer_step_timer.sv
// Step timer: counts clock cycles within one pattern step and produces
// strobes for the start of the trailing gap and for the last cycle of the step.
module step_timer #(
  parameter  int STEP_CYCLES = 8,
  parameter  int GAP_CYCLES  = 2,
  localparam int CW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear_i,
  input  logic run_i,
  output logic gap_hit_o,
  output logic step_end_o
);

  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam int GAP_AT  = STEP_CYCLES - GAP_CYCLES - 1;
  localparam int END_AT  = STEP_CYCLES - 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Strobes are only meaningful while the timer is running.
  always_comb begin
    step_end_o = run_i && (cnt_q == CW'(END_AT));
    gap_hit_o  = run_i && HAS_GAP && (cnt_q == CW'(GAP_AT));
  end

  // Next count: sync clear wins, then wrap at the end of the step.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (step_end_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: plays the built-in 16-step melody at a fixed tempo, driving
// the oscillator note select and an articulation GATE.
// Optional feature macro: SEQ_LOOP_EN -- when defined the pattern loops
// forever; when undefined playback ends in a DONE state with a DONE pulse.
module note_sequencer
  import iv_audio_pkg::*;
#(
  parameter int STEP_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 781_250,
  parameter int SEQ_LEN     = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  note_sequencer_if.slave   bus
);

  localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

  seq_state_t state_q, state_d;
  note_t      note_q,  note_d;
  logic       gate_q,  gate_d;
  logic [3:0] idx_q,   idx_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  logic       step_end;
  logic       gap_hit;
  logic       timer_clear;
  logic       timer_run;
  logic       at_last;
  logic [3:0] next_idx;
  step_t      next_step;
  step_t      first_step;

  // Timer runs only while playing; any accepted command restarts it at 0.
  always_comb begin
    timer_run   = (state_q == ST_PLAY);
    timer_clear = bus.START || bus.STOP || (state_q != ST_PLAY);
  end

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clear_i    (timer_clear),
    .run_i      (timer_run),
    .gap_hit_o  (gap_hit),
    .step_end_o (step_end)
  );

  // Pattern lookup for the step that follows the current one.
  always_comb begin
    at_last    = (idx_q == LAST_IDX);
    next_idx   = at_last ? 4'd0 : (idx_q + 4'd1);
    next_step  = pattern_step(next_idx);
    first_step = pattern_step(4'd0);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      note_q  <= NOTE_FS5;
      gate_q  <= 1'b0;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      gate_q  <= gate_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: STOP beats START; the last step either wraps or finishes.
  always_comb begin
    state_d = state_q;
    if (bus.STOP) begin
      state_d = ST_IDLE;
    end else if (bus.START) begin
      state_d = ST_PLAY;
    end else if ((state_q == ST_PLAY) && step_end && at_last) begin
`ifdef SEQ_LOOP_EN
      state_d = ST_PLAY;
`else
      state_d = ST_DONE;
`endif
    end
  end

  // Next output values; rest steps keep the previous note so the oscillator
  // is never retuned during silence.
  always_comb begin
    note_d = note_q;
    gate_d = gate_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (bus.STOP) begin
      gate_d = 1'b0;
      busy_d = 1'b0;
      idx_d  = 4'd0;
    end else if (bus.START) begin
      idx_d  = 4'd0;
      note_d = first_step.note;
      gate_d = !first_step.rest;
      busy_d = 1'b1;
    end else if (state_q == ST_PLAY) begin
      if (step_end) begin
`ifdef SEQ_LOOP_EN
        idx_d  = next_idx;
        gate_d = !next_step.rest;
        if (!next_step.rest) begin
          note_d = next_step.note;
        end
`else
        if (at_last) begin
          gate_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d  = next_idx;
          gate_d = !next_step.rest;
          if (!next_step.rest) begin
            note_d = next_step.note;
          end
        end
`endif
      end else if (gap_hit) begin
        gate_d = 1'b0;
      end
    end
  end

  assign bus.NOTE_SEL  = note_q;
  assign bus.GATE      = gate_q;
  assign bus.STEP_IDX  = idx_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (GAP=2 and GAP=0, STEP=8) share the
// same command stream and are checked every cycle against a timeline model.
module tb_note_sequencer;
  import iv_audio_pkg::*;

  localparam int S   = 8;
  localparam int LEN = 16;
  localparam int GAP [2] = '{2, 0};

  // Melody as note numbers, -1 marks a rest.
  int pat [16] = '{0, 1, 2, 3, 2, 1, 0, -1, 1, 2, 3, 2, 1, 0, 1, -1};

  logic CLK;
  logic RST_N;
  logic start_r;
  logic stop_r;

  int checks = 0;
  int errors = 0;

  note_sequencer_if ifa ();
  note_sequencer_if ifb ();

  assign ifa.START = start_r;
  assign ifa.STOP  = stop_r;
  assign ifb.START = start_r;
  assign ifb.STOP  = stop_r;

  note_sequencer #(.STEP_CYCLES(S), .GAP_CYCLES(2), .SEQ_LEN(LEN)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(ifa));
  note_sequencer #(.STEP_CYCLES(S), .GAP_CYCLES(0), .SEQ_LEN(LEN)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(ifb));

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 playing, 2 finished. t = cycles since the pattern started.
  int   m_mode [2];
  int   m_t    [2];
  int   m_note [2];
  bit   m_done [2];
  logic [8:0] exp_q_a [$];
  logic [8:0] exp_q_b [$];

  function automatic int note_at(input int s);
    for (int i = s; i >= 0; i--) begin
      if (pat[i] >= 0) return pat[i];
    end
    return 0;
  endfunction

  // Packed as {note[1:0], gate, step_idx[3:0], busy, done}.
  function automatic logic [8:0] model_vec(input int k);
    logic [1:0] n;
    logic       g;
    logic [3:0] ix;
    logic       b;
    logic       d;
    int         s;
    int         c;
    n = 2'(m_note[k]); g = 1'b0; ix = 4'd0; b = 1'b0; d = 1'b0;
    if (m_mode[k] == 1) begin
      s  = m_t[k] / S;
      c  = m_t[k] % S;
      n  = 2'(note_at(s));
      g  = (pat[s] >= 0) && (c < S - GAP[k]);
      ix = 4'(s);
      b  = 1'b1;
    end else if (m_mode[k] == 2) begin
      ix = 4'(LEN - 1);
      d  = m_done[k];
    end
    return {n, g, ix, b, d};
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_t[k] = 0; m_note[k] = 0; m_done[k] = 1'b0;
      end
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] = 1'b0;
        if (stop_r) begin
          m_mode[k] = 0;
        end else if (start_r) begin
          m_mode[k] = 1;
          m_t[k]    = 0;
        end else if (m_mode[k] == 1) begin
          if (m_t[k] == S * LEN - 1) begin
`ifdef SEQ_LOOP_EN
            m_t[k] = 0;
`else
            m_mode[k] = 2;
            m_done[k] = 1'b1;
`endif
          end else begin
            m_t[k] = m_t[k] + 1;
          end
        end
        if (m_mode[k] == 1) m_note[k] = note_at(m_t[k] / S);
      end
      exp_q_a.push_back(model_vec(0));
      exp_q_b.push_back(model_vec(1));
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int state_num(input seq_state_t st);
    return (st == ST_IDLE) ? 0 : (st == ST_PLAY) ? 1 : 2;
  endfunction

  wire logic [8:0] act_a = {ifa.NOTE_SEL, ifa.GATE, ifa.STEP_IDX, ifa.BUSY, ifa.DONE};
  wire logic [8:0] act_b = {ifb.NOTE_SEL, ifb.GATE, ifb.STEP_IDX, ifb.BUSY, ifb.DONE};

  always @(negedge CLK) begin
    logic [8:0] e;
    if (!RST_N) begin
      chk("rst_a", 32'(act_a), 32'd0);
      chk("rst_b", 32'(act_b), 32'd0);
    end else begin
      if (exp_q_a.size() > 0) begin
        e = exp_q_a.pop_front();
        chk("cmp_a", 32'(act_a), 32'(e));
        chk("state_a", 32'(state_num(ifa.dbg_state)), 32'(m_mode[0]));
      end
      if (exp_q_b.size() > 0) begin
        e = exp_q_b.pop_front();
        chk("cmp_b", 32'(act_b), 32'(e));
        chk("state_b", 32'(state_num(ifb.dbg_state)), 32'(m_mode[1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse(input logic st, input logic sp);
    @(negedge CLK);
    start_r = st;
    stop_r  = sp;
    @(negedge CLK);
    start_r = 1'b0;
    stop_r  = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int r;
    RST_N   = 1'b0;
    start_r = 1'b0;
    stop_r  = 1'b0;
    cycles(5);
    chk("reset_outputs_a", 32'(act_a), 32'd0);
    #1 RST_N = 1'b1;
    cycles(50);
    chk("idle_50_a", 32'(act_a), 32'd0);
    chk("idle_50_b", 32'(act_b), 32'd0);

    // First step loads immediately; gap starts after 6 cycles.
    pulse(1'b1, 1'b0);                      // now at t=0
    chk("start_busy", 32'(ifa.BUSY), 32'd1);
    chk("start_note", 32'(ifa.NOTE_SEL), 32'd0);
    chk("start_gate", 32'(ifa.GATE), 32'd1);
    cycles(5);                              // t=5
    chk("gate_before_gap", 32'(ifa.GATE), 32'd1);
    cycles(1);                              // t=6
    chk("gate_in_gap", 32'(ifa.GATE), 32'd0);
    chk("gate_nogap_b", 32'(ifb.GATE), 32'd1);
    cycles(2);                              // t=8, step 1
    chk("step1_gate", 32'(ifa.GATE), 32'd1);
    chk("step1_note", 32'(ifa.NOTE_SEL), 32'd1);
    chk("step1_idx", 32'(ifa.STEP_IDX), 32'd1);

    // Step 7 is a rest: silent, previous note held.
    cycles(48);                             // t=56, step 7
    chk("rest_idx", 32'(ifa.STEP_IDX), 32'd7);
    chk("rest_gate", 32'(ifa.GATE), 32'd0);
    chk("rest_note", 32'(ifa.NOTE_SEL), 32'd0);
    chk("rest_gate_b", 32'(ifb.GATE), 32'd0);
    cycles(8);                              // t=64, step 8
    chk("step8_note", 32'(ifa.NOTE_SEL), 32'd1);
    chk("step8_gate", 32'(ifa.GATE), 32'd1);

    // End of pattern, 128 cycles after the start.
    cycles(64);
`ifdef SEQ_LOOP_EN
    chk("wrap_done", 32'(ifa.DONE), 32'd0);
    chk("wrap_idx", 32'(ifa.STEP_IDX), 32'd0);
    chk("wrap_note", 32'(ifa.NOTE_SEL), 32'd0);
    chk("wrap_gate", 32'(ifa.GATE), 32'd1);
    chk("wrap_busy", 32'(ifa.BUSY), 32'd1);
`else
    chk("end_done", 32'(ifa.DONE), 32'd1);
    chk("end_busy", 32'(ifa.BUSY), 32'd0);
    chk("end_idx", 32'(ifa.STEP_IDX), 32'd15);
    chk("end_note", 32'(ifa.NOTE_SEL), 32'd1);
    cycles(1);
    chk("done_one_cycle", 32'(ifa.DONE), 32'd0);
`endif

    // START+STOP together at step 5: STOP wins.
    pulse(1'b1, 1'b0);
    cycles(43);                             // step 5, cnt 3
    pulse(1'b1, 1'b1);
    chk("both_busy", 32'(ifa.BUSY), 32'd0);
    chk("both_gate", 32'(ifa.GATE), 32'd0);
    chk("both_idx", 32'(ifa.STEP_IDX), 32'd0);
    chk("both_note_held", 32'(ifa.NOTE_SEL), 32'd1);

    // START alone mid-pattern restarts the step timer.
    pulse(1'b1, 1'b0);
    cycles(43);
    pulse(1'b1, 1'b0);
    chk("restart_idx", 32'(ifa.STEP_IDX), 32'd0);
    chk("restart_note", 32'(ifa.NOTE_SEL), 32'd0);
    chk("restart_gate", 32'(ifa.GATE), 32'd1);
    cycles(6);
    chk("restart_gap", 32'(ifa.GATE), 32'd0);
    chk("restart_gap_idx", 32'(ifa.STEP_IDX), 32'd0);

    // Asynchronous reset in the middle of step 3.
    cycles(21);                             // t=27
    chk("nogap_step3_gate", 32'(ifb.GATE), 32'd1);
    chk("nogap_step3_note", 32'(ifb.NOTE_SEL), 32'd3);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_a", 32'(act_a), 32'd0);
    chk("async_rst_b", 32'(act_b), 32'd0);
    @(negedge CLK);
    #1 RST_N = 1'b1;

    // Random command stream checked by the per-cycle model comparison.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      r       = int'($urandom_range(0, 999));
      start_r = (r < 4) || (r == 7);
      stop_r  = (r >= 4 && r < 8);
    end
    @(negedge CLK);
    start_r = 1'b0;
    stop_r  = 1'b0;
    cycles(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
